// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous memory between a CPU and a video/display
// reader. Each access takes three cycles (IDLE grant, ACCESS strobe, RESP ack).
// Video normally has priority; a starvation counter guarantees the CPU a slot
// after VID_BURST consecutive video grants made while the CPU was waiting.
//
// Parameters
//   ADDR_W     memory word-address width
//   DATA_W     memory data width
//   VID_BURST  max consecutive video grants while the CPU waits
//
// Ports
//   clk        clock, all state changes on the rising edge
//   Reset      synchronous active-high reset
//   cpu_req    CPU request, held until cpu_ack
//   cpu_we     CPU write (1) / read (0)
//   cpu_addr   CPU address
//   cpu_wdata  CPU store data
//   cpu_ack    one-cycle CPU completion pulse
//   cpu_rdata  CPU load data, valid with cpu_ack, held between acks
//   vid_req    video read request, held until vid_ack
//   vid_addr   video read address
//   vid_ack    one-cycle video completion pulse
//   vid_rdata  video read data, valid with vid_ack, held between acks
//   mem_en     memory access strobe
//   mem_we     memory write enable
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_rdata  memory read data, valid the cycle after mem_en
//   busy       high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int VID_BURST = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_CPU, OWN_VID} owner_t;

    localparam int CNT_W = (VID_BURST < 1) ? 1 : $clog2(VID_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(VID_BURST);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;

    logic cpu_win;
    logic resp_cpu;
    logic resp_vid;

    // CPU takes the slot when video is absent, or when video has already been
    // granted VID_BURST times in a row while the CPU was waiting.
    assign cpu_win = cpu_req && (!vid_req || (starve_q == BURST_MAX));

    // NOTE: every _d is defaulted to its _q before the case, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        starve_d    = starve_q;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (!cpu_req) begin
                    starve_d = '0;
                end
                if (cpu_req || vid_req) begin
                    state_d = ACCESS;
                    if (cpu_win) begin
                        owner_d  = OWN_CPU;
                        addr_d   = cpu_addr;
                        we_d     = cpu_we;
                        wdata_d  = cpu_wdata;
                        starve_d = '0;
                    end else begin
                        owner_d = OWN_VID;
                        addr_d  = vid_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        if (cpu_req && (starve_q != BURST_MAX)) begin
                            starve_d = starve_q + CNT_W'(1);
                        end
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                // Only reads refresh the requester's data; CPU writes leave it.
                if (owner_q == OWN_CPU) begin
                    if (!we_q) begin
                        cpu_rdata_d = mem_rdata;
                    end
                end else begin
                    vid_rdata_d = mem_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (Reset) begin
            // NOTE: the held read-data registers are reset too, because they
            // drive outputs that must read as zero straight out of reset.
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            starve_q    <= '0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            starve_q    <= starve_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;

    assign resp_cpu = (state_q == RESP) && (owner_q == OWN_CPU);
    assign resp_vid = (state_q == RESP) && (owner_q == OWN_VID);
    assign cpu_ack  = resp_cpu;
    assign vid_ack  = resp_vid;

    // Memory data arrives during RESP, so it is forwarded alongside the ack and
    // captured into the holding register at the end of that cycle.
    assign cpu_rdata = (resp_cpu && !we_q) ? mem_rdata : cpu_rdata_q;
    assign vid_rdata = resp_vid ? mem_rdata : vid_rdata_q;

endmodule
